weight_fetch_unit: RTL and testbench

- Downstream consumer of the weight block RAM (8-bit data, 11-bit address, 1-cycle read latency).
- On a start command, reads a contiguous run of weight bytes from the BRAM port and packs each group of LANES bytes into one vector.
- Presents each vector to the PE array over a valid/ready handshake.
- Sits between the weight BRAM and the systolic array's weight-load input.

---
 rtl/weight_fetch_unit_pkg.sv | 16 +
 rtl/weight_fetch_unit_if.sv | 26 ++
 rtl/weight_fetch_unit_pack.sv | 49 ++++
 rtl/weight_fetch_unit.sv | 130 +++++++++++++
 tb/tb_weight_fetch_unit.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/weight_fetch_unit_pkg.sv
// Shared types and constants for the weight fetch path.
// The BRAM wrapper uses the same address/data widths.
package weight_fetch_unit_pkg;

    localparam int WEIGHT_ADDR_W = 11;
    localparam int WEIGHT_DATA_W = 8;
    localparam int BRAM_RD_LAT   = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } wfu_state_t;

endpackage

// File: rtl/weight_fetch_unit_if.sv
// BRAM read port plus PE-array weight stream, bundled for weight_fetch_unit.
// The master side is the fetch unit; the slave side is the BRAM / PE array.
interface weight_fetch_unit_if
    import weight_fetch_unit_pkg::*;
#(
    parameter int ADDR_W = WEIGHT_ADDR_W,
    parameter int DATA_W = WEIGHT_DATA_W,
    parameter int LANES  = 4
);
    logic                      bram_en;
    logic [ADDR_W-1:0]         bram_addr;
    logic [DATA_W-1:0]         bram_dout;
    logic                      wt_valid;
    logic                      wt_ready;
    logic [LANES*DATA_W-1:0]   wt_data;

    modport master (
        output bram_en, bram_addr, wt_valid, wt_data,
        input  bram_dout, wt_ready
    );

    modport slave (
        input  bram_en, bram_addr, wt_valid, wt_data,
        output bram_dout, wt_ready
    );
endinterface

// File: rtl/weight_fetch_unit_pack.sv
// weight_pack_reg: lane capture register plus the valid/ready output holding register.
// The final lane can be forwarded straight into the output register the cycle it lands.
module weight_pack_reg #(
    parameter int DATA_W = 8,
    parameter int LANES  = 4,
    parameter int LW     = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cap_en,
    input  logic [LW-1:0]           cap_lane,
    input  logic [DATA_W-1:0]       din,
    input  logic                    xfer,
    input  logic                    wt_ready,
    output logic                    wt_valid,
    output logic [LANES*DATA_W-1:0] wt_data
);
    localparam int VW = LANES * DATA_W;

    logic [VW-1:0] lanes_p1;
    logic [VW-1:0] pack_nxt;

    always_comb begin
        pack_nxt = lanes_p1;
        for (int k = 0; k < LANES; k++) begin
            if (cap_en && (cap_lane == LW'(k))) begin
                pack_nxt[k*DATA_W +: DATA_W] = din;
            end
        end
    end

    // stage p1: pack register (data only, no reset)
    always_ff @(posedge clk) begin
        lanes_p1 <= pack_nxt;
    end

    // stage p2: output holding register
    always_ff @(posedge clk) begin
        if (reset) begin
            wt_valid <= 1'b0;
            wt_data  <= '0;
        end else if (xfer) begin
            wt_valid <= 1'b1;
            wt_data  <= pack_nxt;
        end else if (wt_valid && wt_ready) begin
            wt_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/weight_fetch_unit.sv
// Streams num_vec packed LANES-byte weight vectors from the weight BRAM to the PE array.
// Optional WEIGHT_FETCH_STALL_CNT_EN adds a saturating stall_cycles counter output.
module weight_fetch_unit
    import weight_fetch_unit_pkg::*;
#(
    parameter int ADDR_W = WEIGHT_ADDR_W,
    parameter int DATA_W = WEIGHT_DATA_W,
    parameter int LANES  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_vec,
    output logic              busy,
    output logic              done,
`ifdef WEIGHT_FETCH_STALL_CNT_EN
    output logic [15:0]       stall_cycles,
`endif
    weight_fetch_unit_if.master bus
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    wfu_state_t              state_q, state_d;
    logic [ADDR_W-1:0]       addr_q;
    logic [CNT_W-1:0]        vec_q;
    logic [LW-1:0]           iss_lane_q;
    logic                    rd_vld_p1;
    logic [LW-1:0]           rd_lane_p1;
    logic                    issue, last_issue, xfer;
    logic                    wt_valid;
    logic [LANES*DATA_W-1:0] wt_data;

    assign issue      = (state_q == ISSUE);
    assign last_issue = issue && (iss_lane_q == LW'(LANES - 1));
    // Issue is stalled in DRAIN, so the pack register is free until this transfer happens.
    assign xfer       = (state_q == DRAIN) && (!wt_valid || bus.wt_ready);

    assign bus.bram_en   = issue;
    assign bus.bram_addr = addr_q;
    assign bus.wt_valid  = wt_valid;
    assign bus.wt_data   = wt_data;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (num_vec == '0) ? FINISH : ISSUE;
            ISSUE:   if (last_issue) state_d = DRAIN;
            DRAIN:   if (xfer) state_d = (vec_q == CNT_W'(1)) ? FINISH : ISSUE;
            FINISH:  if (!wt_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // stage p0: control, address issue and the BRAM read-latency valid
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            vec_q      <= '0;
            iss_lane_q <= '0;
            rd_vld_p1  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q   <= state_d;
            done      <= 1'b0;
            rd_vld_p1 <= issue;
            case (state_q)
                IDLE: if (start) begin
                    addr_q     <= base_addr;
                    vec_q      <= num_vec;
                    iss_lane_q <= '0;
                    busy       <= 1'b1;
                end
                ISSUE: begin
                    addr_q     <= addr_q + ADDR_W'(1);
                    iss_lane_q <= last_issue ? '0 : iss_lane_q + LW'(1);
                end
                DRAIN:  if (xfer) vec_q <= vec_q - CNT_W'(1);
                FINISH: if (!wt_valid) begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        rd_lane_p1 <= iss_lane_q;
    end

    weight_pack_reg #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .LW     (LW)
    ) u_pack (
        .clk      (clk),
        .reset    (reset),
        .cap_en   (rd_vld_p1),
        .cap_lane (rd_lane_p1),
        .din      (bus.bram_dout),
        .xfer     (xfer),
        .wt_ready (bus.wt_ready),
        .wt_valid (wt_valid),
        .wt_data  (wt_data)
    );

`ifdef WEIGHT_FETCH_STALL_CNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if ((state_q == IDLE) && start) begin
            stall_q <= '0;
        end else if (wt_valid && !bus.wt_ready) begin
            stall_q <= sat_inc16(stall_q);
        end
    end

    assign stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_weight_fetch_unit.sv
// Bench for weight_fetch_unit: table of runs plus hand-written backpressure/reset/restart sequences.
module tb_weight_fetch_unit;
    import weight_fetch_unit_pkg::*;

    localparam int AW = 11;
    localparam int DW = 8;
    localparam int LN = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [CW-1:0] num_vec;
    logic          busy;
    logic          done;
`ifdef WEIGHT_FETCH_STALL_CNT_EN
    logic [15:0]   stall_cycles;
`endif

    weight_fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW), .LANES(LN)) bus();

    weight_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .LANES(LN), .CNT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .base_addr    (base_addr),
        .num_vec      (num_vec),
        .busy         (busy),
        .done         (done),
`ifdef WEIGHT_FETCH_STALL_CNT_EN
        .stall_cycles (stall_cycles),
`endif
        .bus          (bus)
    );

    always #5 clk = ~clk;

    // BRAM model: one-cycle registered read
    logic [DW-1:0] mem [2**AW];
    always @(posedge clk) begin
        if (bus.bram_en) bus.bram_dout <= mem[bus.bram_addr];
    end

    typedef struct {
        logic [AW-1:0] base;
        logic [CW-1:0] num;
        logic [31:0]   first;
        int            en;
    } vec_t;

    vec_t        tbl [5];
    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          en_cnt = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    logic [31:0] exp_q [$];
    logic [31:0] got_q [$];
    int          hs_q [$];
    bit          prev_stall = 1'b0;
    logic [31:0] held;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.bram_en) en_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (prev_stall && bus.wt_valid) chk("hold_stable", bus.wt_data, held);
        prev_stall = bus.wt_valid && !bus.wt_ready;
        held       = bus.wt_data;
        if (bus.wt_valid && bus.wt_ready) begin
            got_q.push_back(bus.wt_data);
            hs_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_vec: got %h, scoreboard empty", bus.wt_data);
            end else begin
                chk("vec_data", bus.wt_data, exp_q.pop_front());
            end
        end
    end

    task automatic push_exp(input logic [AW-1:0] b, input logic [CW-1:0] n);
        for (int v = 0; v < int'(n); v++) begin
            logic [31:0] w;
            for (int l = 0; l < LN; l++) w[l*DW +: DW] = mem[AW'(int'(b) + v*LN + l)];
            exp_q.push_back(w);
        end
    endtask

    task automatic pulse_start(input logic [AW-1:0] b, input logic [CW-1:0] n);
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; num_vec = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // lat counts clock edges after the edge that samples start
    task automatic run(input vec_t tv, input bit bp, input bit dbl);
        int en0, got0, hs0, d0, lat, en_s;
        bit seen;
        en0 = en_cnt; got0 = got_q.size(); hs0 = hs_q.size(); d0 = done_cnt;
        push_exp(tv.base, tv.num);
        pulse_start(tv.base, tv.num);
        chk("busy_after_start", 32'(busy), 32'd1);
        lat = 0; seen = 1'b0;
        for (int i = 1; i <= 60 && !seen; i++) begin
            @(posedge clk); #1;
            if (dbl) begin
                if (i == 2) begin
                    start = 1'b1; base_addr = 11'h500; num_vec = 16'd5;
                end else begin
                    start = 1'b0;
                end
            end
            if ((tv.num != 0 && bus.wt_valid) || (tv.num == 0 && done)) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        if (bp && seen) begin
            bus.wt_ready = 1'b0;
            en_s = en_cnt;
            repeat (10) @(posedge clk);
            #1;
            chk("reads_while_blocked", 32'(en_cnt - en_s), 32'(LN));
            bus.wt_ready = 1'b1;
        end
        for (int t = 0; t < 400 && done_cnt == d0; t++) @(negedge clk);
        repeat (6) @(negedge clk);
        // zero count: done lands two cycles after the start-pulse cycle
        chk("latency", 32'(lat), (tv.num != 0) ? 32'(LN + 1) : 32'd1);
        chk("done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("bram_en_cycles", 32'(en_cnt - en0), 32'(tv.en));
        chk("vectors", 32'(got_q.size() - got0), 32'(tv.num));
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        chk("busy_after_done", 32'(busy), 32'd0);
        if (tv.num != 0) begin
            chk("first_vec", (got_q.size() > got0) ? got_q[got0] : 32'hDEAD_BEEF, tv.first);
            chk("done_after_last_hs",
                32'((hs_q.size() > hs0) && (done_cyc > hs_q[hs_q.size()-1])), 32'd1);
        end
        if (tv.num > 1 && !bp)
            chk("throughput", (hs_q.size() > hs0 + 1) ? 32'(hs_q[hs0+1] - hs_q[hs0]) : 32'd0,
                32'(LN + 1));
`ifdef WEIGHT_FETCH_STALL_CNT_EN
        if (bp) chk("stall_cycles", 32'(stall_cycles), 32'd10);
`endif
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int en0, got0, d0;
        tbl[0] = '{11'h000, 16'd2, 32'h03020100, 8};
        tbl[1] = '{11'h7FE, 16'd1, 32'h0100FFFE, 4};
        tbl[2] = '{11'h100, 16'd3, 32'h03020100, 12};
        tbl[3] = '{11'h000, 16'd0, 32'h00000000, 0};
        tbl[4] = '{11'h055, 16'd1, 32'h58575655, 4};

        reset = 1'b1; start = 1'b0; base_addr = '0; num_vec = '0; bus.wt_ready = 1'b1;
        for (int a = 0; a < 2**AW; a++) mem[a] = 8'(a);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bram_en", 32'(bus.bram_en), 32'd0);
        chk("rst_bram_addr", 32'(bus.bram_addr), 32'd0);
        chk("rst_wt_valid", 32'(bus.wt_valid), 32'd0);
        chk("rst_wt_data", bus.wt_data, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) run(tbl[i], 1'b0, 1'b0);

        run('{11'h020, 16'd3, 32'h23222120, 12}, 1'b1, 1'b0);
        run('{11'h010, 16'd2, 32'h13121110, 8}, 1'b0, 1'b1);

        // reset during the second vector's issue phase
        en0 = en_cnt; got0 = got_q.size(); d0 = done_cnt;
        push_exp(11'h040, 16'd2);
        pulse_start(11'h040, 16'd2);
        for (int t = 0; t < 50 && (en_cnt - en0) < LN + 1; t++) @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_bram_en", 32'(bus.bram_en), 32'd0);
        chk("midrst_bram_addr", 32'(bus.bram_addr), 32'd0);
        chk("midrst_wt_valid", 32'(bus.wt_valid), 32'd0);
        chk("midrst_wt_data", bus.wt_data, 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        reset = 1'b0;
        exp_q.delete();
        repeat (10) @(negedge clk);
        chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        chk("midrst_vectors", 32'(got_q.size() - got0), 32'd1);
        run('{11'h300, 16'd1, 32'h03020100, 4}, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
